// File: rtl/cpu_mem_subsys.sv
// cpu_mem_subsys: combinational instruction ROM, data RAM with 0..7-cycle read latency and stall handshake, preload port.
// Optional load/store counters are built only when MEM_ACCESS_CNT_EN is defined.
module cpu_mem_subsys #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter int                IMEM_DEPTH = 128,
    parameter int                DMEM_DEPTH = 128,
    parameter int                RD_LATENCY = 1,
    parameter logic [DATA_W-1:0] NOP_INSTR  = 32'h00000013
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   instr_addr,
    output logic [DATA_W-1:0]   instruction,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_out,
    output logic [DATA_W-1:0]   data_in,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic                mem_stall,
    output logic                addr_err,
    input  logic                init_we,
    input  logic                init_sel,
    input  logic [15:0]         init_addr,
    input  logic [DATA_W-1:0]   init_data,
    output logic [31:0]         rd_cnt,
    output logic [31:0]         wr_cnt
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = ADDR_W - 2;
    localparam int IMW   = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int DMW   = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
    localparam logic [IDX_W-1:0] IMEM_LIM   = IDX_W'(IMEM_DEPTH);
    localparam logic [IDX_W-1:0] DMEM_LIM   = IDX_W'(DMEM_DEPTH);
    localparam logic [15:0]      IMEM_LIM16 = 16'(IMEM_DEPTH);
    localparam logic [15:0]      DMEM_LIM16 = 16'(DMEM_DEPTH);
    localparam logic [2:0]       CNT_INIT   = 3'(RD_LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    logic [DATA_W-1:0] r_imem [IMEM_DEPTH];
    logic [DATA_W-1:0] r_dmem [DMEM_DEPTH];

    logic [IDX_W-1:0]  w_iidx;
    logic [IDX_W-1:0]  w_didx;
    logic              w_i_ok;
    logic              w_d_ok;
    logic              w_init_i_ok;
    logic              w_init_d_ok;
    logic              w_idle;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_err_set;
    logic              w_init_hit;
    logic [DATA_W-1:0] w_be_mask;
    logic [DATA_W-1:0] w_st_word;
    logic              r_addr_err;
`ifdef MEM_ACCESS_CNT_EN
    logic              w_rd_done;
`endif

    assign w_iidx      = instr_addr[ADDR_W-1:2];
    assign w_didx      = data_addr[ADDR_W-1:2];
    assign w_i_ok      = (w_iidx < IMEM_LIM);
    assign w_d_ok      = (w_didx < DMEM_LIM);
    assign w_init_i_ok = (init_addr < IMEM_LIM16);
    assign w_init_d_ok = (init_addr < DMEM_LIM16);

    assign instruction = w_i_ok ? r_imem[w_iidx[IMW-1:0]] : NOP_INSTR;

    // Requests are only taken in IDLE and out of reset; a write shadows a simultaneous read.
    assign w_wr_acc = rst & w_idle & mem_write;
    assign w_rd_acc = rst & w_idle & mem_read & ~mem_write;

    assign w_err_set = (|instr_addr[1:0])
                     | (w_idle & (mem_read | mem_write)
                        & ((|data_addr[1:0]) | ~w_d_ok | (mem_read & mem_write)));

    always_comb begin
        w_be_mask = '0;
        for (int k = 0; k < BE_W; k++) begin
            w_be_mask[8*k +: 8] = {8{byte_en[k]}};
        end
    end

    assign w_st_word  = (r_dmem[w_didx[DMW-1:0]] & ~w_be_mask) | (data_out & w_be_mask);
    assign w_init_hit = init_we & init_sel & w_init_d_ok
                      & (init_addr[DMW-1:0] == w_didx[DMW-1:0]);

    always_ff @(posedge clk) begin
        if (init_we && !init_sel && w_init_i_ok) begin
            r_imem[init_addr[IMW-1:0]] <= init_data;
        end
    end

    // Preload wins over a CPU store that lands on the same word in the same cycle.
    always_ff @(posedge clk) begin
        if (init_we && init_sel && w_init_d_ok) begin
            r_dmem[init_addr[DMW-1:0]] <= init_data;
        end
        if (w_wr_acc && w_d_ok && !w_init_hit) begin
            r_dmem[w_didx[DMW-1:0]] <= w_st_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr_err <= 1'b0;
        end else if (w_err_set) begin
            r_addr_err <= 1'b1;
        end
    end
    assign addr_err = r_addr_err;

    if (RD_LATENCY == 0) begin : g_comb
        assign w_idle    = 1'b1;
        assign mem_stall = 1'b0;
        assign data_in   = (w_rd_acc && w_d_ok) ? r_dmem[w_didx[DMW-1:0]] : '0;
`ifdef MEM_ACCESS_CNT_EN
        assign w_rd_done = w_rd_acc;
`endif
    end else begin : g_seq
        state_t            r_state;
        state_t            w_state_nxt;
        logic [2:0]        r_cnt;
        logic [2:0]        w_cnt_nxt;
        logic [DMW-1:0]    r_req_idx;
        logic              r_req_ok;
        logic [DATA_W-1:0] r_data;
        logic              w_req_ld;
        logic              w_data_ld;
        logic              w_stall;
        logic [DMW-1:0]    w_src_idx;
        logic              w_src_ok;
        logic [DATA_W-1:0] w_ld_word;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state   <= S_IDLE;
                r_cnt     <= '0;
                r_req_idx <= '0;
                r_req_ok  <= 1'b0;
                r_data    <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                if (w_req_ld) begin
                    r_req_idx <= w_didx[DMW-1:0];
                    r_req_ok  <= w_d_ok;
                end
                if (w_data_ld) begin
                    r_data <= w_ld_word;
                end
            end
        end

        // r_cnt==1 here means the decrement reaches zero on this edge: N stall cycles in total.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_req_ld    = 1'b0;
            w_data_ld   = 1'b0;
            w_stall     = 1'b0;
            w_src_idx   = r_req_idx;
            w_src_ok    = r_req_ok;
            case (r_state)
                S_IDLE: begin
                    if (w_rd_acc) begin
                        w_req_ld  = 1'b1;
                        w_stall   = 1'b1;
                        w_cnt_nxt = CNT_INIT;
                        if (RD_LATENCY == 1) begin
                            w_data_ld   = 1'b1;
                            w_src_idx   = w_didx[DMW-1:0];
                            w_src_ok    = w_d_ok;
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        w_data_ld   = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end

        assign w_ld_word = w_src_ok ? r_dmem[w_src_idx] : '0;
        assign w_idle    = (r_state == S_IDLE);
        assign mem_stall = w_stall;
        assign data_in   = r_data;
`ifdef MEM_ACCESS_CNT_EN
        assign w_rd_done = (r_state == S_DONE);
`endif
    end

`ifdef MEM_ACCESS_CNT_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_rd_done) r_rd_cnt <= r_rd_cnt + 32'd1;
            if (w_wr_acc)  r_wr_cnt <= r_wr_cnt + 32'd1;
        end
    end
    assign rd_cnt = r_rd_cnt;
    assign wr_cnt = r_wr_cnt;
`else
    assign rd_cnt = '0;
    assign wr_cnt = '0;
`endif

endmodule

// File: doc/cpu_mem_subsys.md
Name: cpu_mem_subsys

Overview:
Parametrised instruction/data memory subsystem for the 32-bit 5-stage pipelined CPU. It replaces the ad-hoc zero-latency arrays used in CPU benches with one block that provides:
- a combinational instruction ROM port;
- a data RAM port with configurable read latency, a stall handshake, byte enables and out-of-range detection;
- a preload port for loading program and data images before the CPU is released from reset.

It sits directly between the cpu instance and the bench, using the CPU's existing instr/data port names.

Parameters:
- DATA_W, 32, data and instruction word width; must be a multiple of 8.
- ADDR_W, 32, byte address width on both CPU ports.
- IMEM_DEPTH, 128, instruction ROM depth in words.
- DMEM_DEPTH, 128, data RAM depth in words.
- RD_LATENCY, 1, data read latency in cycles, range 0..7; 0 means combinational.
- NOP_INSTR, 32'h00000013, word returned for an out-of-range fetch.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- instr_addr  input  ADDR_W  byte address of the instruction fetch.
- instruction  output  DATA_W  fetched instruction word.
- data_addr  input  ADDR_W  byte address of the data access.
- data_out  input  DATA_W  store data from the CPU.
- data_in  output  DATA_W  load data to the CPU.
- mem_read  input  1  load request.
- mem_write  input  1  store request.
- byte_en  input  DATA_W/8  store byte strobes.
- mem_stall  output  1  CPU must hold the request and freeze the pipeline.
- addr_err  output  1  sticky flag: out-of-range, misaligned or conflicting access.
- init_we  input  1  preload write strobe.
- init_sel  input  1  preload target: 0 = instruction ROM, 1 = data RAM.
- init_addr  input  16  preload word index.
- init_data  input  DATA_W  preload word.
- rd_cnt  output  32  completed load count (optional feature).
- wr_cnt  output  32  completed store count (optional feature).

Behaviour:
- Word index is addr[ADDR_W-1:2]. Any addr[1:0] != 0 sets addr_err; the access still proceeds as word-aligned.
- Instruction port:
  - Combinational: instruction = IMEM[index] when index < IMEM_DEPTH, otherwise NOP_INSTR.
  - Never stalls; out-of-range fetch does not set addr_err.
- Reset (rst low, asynchronous, any time including mid-read):
  - FSM to IDLE; mem_stall=0; data_in=0; addr_err=0; counters=0.
  - Memory contents are NOT cleared.
- Store:
  - Single cycle and posted, never stalls.
  - At the rising edge with mem_write=1 and FSM in IDLE, each byte lane k with byte_en[k]=1 is written from data_out[8k+7:8k].
  - Out-of-range index: write dropped, addr_err set.
- Load with RD_LATENCY=0:
  - data_in = DMEM[index] combinationally while mem_read=1; mem_stall stays 0.
  - Out-of-range index returns 0 and sets addr_err.
- Load with RD_LATENCY=N>0: FSM has states IDLE, WAIT, DONE.
  - IDLE, mem_read=1:
    - Latch the index into a request register.
    - mem_stall goes high combinationally in the same cycle.
    - Load counter with N-1; go to WAIT, or to DONE directly when N=1.
  - WAIT: mem_stall=1; counter decrements each cycle; at 0, register data_in and go to DONE.
  - DONE:
    - mem_stall=0 and data_in holds the latched word for exactly this cycle; the CPU samples it here.
    - Return to IDLE next cycle.
    - A new mem_read present in DONE is not accepted until IDLE; no back-to-back acceptance.
  - Result: total stall is N cycles; data is valid N cycles after the request edge.
  - data_in holds its last value in IDLE; it is not zeroed.
- Both mem_read and mem_write in IDLE: the write wins, the read is ignored, addr_err is set.
- mem_write asserted while the FSM is not IDLE: ignored; the CPU must hold it until the stall clears.
- Preload:
  - init_we writes init_data at init_addr into the array selected by init_sel, on the rising edge.
  - Out-of-range preload is dropped silently.
  - Preload has priority over a CPU store to the same data word in the same cycle.
- addr_err clears only on reset.

Optional Feature:
MEM_ACCESS_CNT_EN
- Defined: rd_cnt increments on each completed load (the DONE cycle, or each mem_read cycle when RD_LATENCY=0); wr_cnt increments on each accepted store. Both count dropped out-of-range accesses and wrap modulo 2^32.
- Undefined: rd_cnt and wr_cnt are tied to 0 and no counter flops exist.

Test Plan:
1. Preload IMEM[0]=32'h00400093, IMEM[1]=32'hffc0a203, then release reset -> instruction=32'h00400093 at instr_addr=0 and 32'hffc0a203 at instr_addr=4; instr_addr=0x400 returns 32'h00000013.
2. RD_LATENCY=3, DMEM[5]=32'd777, mem_read at addr 0x14 -> mem_stall high for exactly 3 cycles; data_in=777 in the DONE cycle; rd_cnt=1 with MEM_ACCESS_CNT_EN.
3. RD_LATENCY=0, DMEM[1]=32'h11223344, store 32'hAABBCCDD with byte_en=4'b0101 to addr 4, then load addr 4 -> 32'h11BB33DD, no stall, wr_cnt=1.
4. Load addr 0x200 (index 128, DMEM_DEPTH=128) -> data_in=0, addr_err=1 and stays 1; a subsequent store to the same address leaves all memory unchanged.
5. RD_LATENCY=4, drop rst low 2 cycles after a load request -> mem_stall=0 and data_in=0 immediately (asynchronous); preloaded DMEM contents unchanged after reset.
6. Assert mem_read and mem_write together at addr 8 with data_out=32'd42, byte_en=4'hF -> DMEM[2]=42, no stall, addr_err=1.
